// File: rtl/cram_backup_ctrl_pkg.sv
// rtl/cram_backup_ctrl_pkg.sv - shared types and constants for the cart RAM backup controller
package cram_backup_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LOAD_REQ  = 3'd1,
        LOAD_XFER = 3'd2,
        SAVE_REQ  = 3'd3,
        SAVE_XFER = 3'd4,
        NEXT      = 3'd5
    } state_e;

    localparam int unsigned BLK_BYTES = 512;

endpackage

// File: rtl/cram_backup_ctrl.sv
// rtl/cram_backup_ctrl.sv - block-at-a-time battery load/save sequencer between cart RAM port B and the SD image
module cram_backup_ctrl
    import cram_backup_ctrl_pkg::*;
#(
    parameter int BLK_W = 8,
    parameter int LBA_W = 32
) (
    input  logic             clk_sys,
    input  logic             reset_n,
    input  logic             ce_cpu,
    input  logic             cpu_ram_wr,
    input  logic             has_battery,
    input  logic [BLK_W-1:0] last_blk,
    input  logic             img_mounted,
    input  logic             img_readonly,
    input  logic [63:0]      img_size,
    input  logic             bk_save,
    output logic [LBA_W-1:0] sd_lba,
    output logic             sd_rd,
    output logic             sd_wr,
    input  logic             sd_ack,
    input  logic [8:0]       sd_buff_addr,
    input  logic             sd_buff_wr,
    input  logic [7:0]       sd_buff_dout,
    output logic [16:0]      ramb_addr,
    output logic             ramb_we,
    output logic [7:0]       ramb_din,
    output logic             busy,
    output logic             dirty
);

    localparam int unsigned OFS_W = $clog2(BLK_BYTES);

    state_e           state_q, state_d;
    logic [BLK_W-1:0] blk_q, blk_d;
    logic             load_q, load_d;
    logic             dirty_q, dirty_d;
    logic             mounted_q, mounted_d;
    logic             readonly_q, readonly_d;
    logic             mount_pend_q, mount_pend_d;
    logic             save_pend_q, save_pend_d;
    logic             save_prev_q;
    logic             sd_rd_q, sd_wr_q;
    logic             save_rise;
    logic [BLK_W+OFS_W-1:0] addr_full;

    assign save_rise = bk_save & ~save_prev_q;

    always_comb begin
        state_d      = state_q;
        blk_d        = blk_q;
        load_d       = load_q;
        dirty_d      = dirty_q;
        mounted_d    = mounted_q;
        readonly_d   = readonly_q;
        mount_pend_d = mount_pend_q;
        save_pend_d  = save_pend_q | (save_rise & (state_q != IDLE));
        ramb_we      = 1'b0;

        // Mount attributes latch immediately; the load itself waits for IDLE.
        if (img_mounted) begin
            mounted_d    = (img_size != 64'd0);
            readonly_d   = img_readonly;
            mount_pend_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (mount_pend_d) begin
                    mount_pend_d = 1'b0;
                    save_pend_d  = save_pend_q | save_rise;
                    if (mounted_d && has_battery) begin
                        state_d = LOAD_REQ;
                        blk_d   = '0;
                        load_d  = 1'b1;
                    end
                end else if (save_rise || save_pend_q) begin
                    save_pend_d = 1'b0;
                    if (mounted_q && !readonly_q && has_battery && dirty_q) begin
                        dirty_d = 1'b0;
                        state_d = SAVE_REQ;
                        blk_d   = '0;
                        load_d  = 1'b0;
                    end
                end
            end
            LOAD_REQ: begin
                if (sd_ack) state_d = LOAD_XFER;
            end
            LOAD_XFER: begin
                ramb_we = sd_buff_wr;
                if (!sd_ack) state_d = NEXT;
            end
            SAVE_REQ: begin
                if (sd_ack) state_d = SAVE_XFER;
            end
            SAVE_XFER: begin
                if (!sd_ack) state_d = NEXT;
            end
            NEXT: begin
                if (blk_q == last_blk) begin
                    state_d = IDLE;
                    if (load_q) dirty_d = 1'b0;
                end else begin
                    blk_d   = blk_q + 1'b1;
                    state_d = load_q ? LOAD_REQ : SAVE_REQ;
                end
            end
            default: state_d = IDLE;
        endcase

        // A CPU write always wins over any clear in the same cycle.
        if (ce_cpu && cpu_ram_wr) dirty_d = 1'b1;
    end

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            blk_q        <= '0;
            load_q       <= 1'b0;
            dirty_q      <= 1'b0;
            mounted_q    <= 1'b0;
            readonly_q   <= 1'b0;
            mount_pend_q <= 1'b0;
            save_pend_q  <= 1'b0;
            save_prev_q  <= 1'b0;
            sd_rd_q      <= 1'b0;
            sd_wr_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            blk_q        <= blk_d;
            load_q       <= load_d;
            dirty_q      <= dirty_d;
            mounted_q    <= mounted_d;
            readonly_q   <= readonly_d;
            mount_pend_q <= mount_pend_d;
            save_pend_q  <= save_pend_d;
            save_prev_q  <= bk_save;
            sd_rd_q      <= (state_d == LOAD_REQ);
            sd_wr_q      <= (state_d == SAVE_REQ);
        end
    end

    assign addr_full = {blk_q, sd_buff_addr};
    assign ramb_addr = 17'(addr_full);
    assign ramb_din  = sd_buff_dout;
    assign sd_lba    = LBA_W'(blk_q);
    assign sd_rd     = sd_rd_q;
    assign sd_wr     = sd_wr_q;
    assign busy      = (state_q != IDLE);
    assign dirty     = dirty_q;

endmodule
